segment_dp: RTL
===============

Name: segment_dp

Overview:
Parametrised dynamic-programming segmentation engine and the successor to the fixed five-formant DP path.
- Consumes a streamed segment-cost triangle E(j,i) from an upstream cost stage.
- Computes the minimum-cost partition of I spectral bins into a run-time-selected K segments, K ≤ MAX_SEG.
- Traces back the boundaries and emits segment end-bins on a ready/valid stream, feeding the phi/frequency stage.
- Adds run-time K, backpressure, saturating arithmetic and a total-cost output.

Parameters:
BIT_WIDTH, 32, cost word width (unsigned)
I, 160, number of bins (depth of each F/B column store)
MAX_SEG, 5, maximum segment count (number of F/B levels)
IDX_W, $clog2(I), bin index width (derived, not overridden)
K_W, $clog2(MAX_SEG+1), segment-count width (derived)

Ports:
clk_in  input  1  clock
rst_n_in  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse; begins a frame when idle
cfg_segs  input  K_W  requested K; latched on accepted start
busy  output  1  high from accepted start until last segment handshake
e_valid  input  1  E word valid
e_ready  output  1  engine accepts E word
e_data  input  BIT_WIDTH  E(j,i), cost of segment spanning bins j..i inclusive
seg_valid  output  1  boundary word valid
seg_ready  input  1  downstream accepts boundary
seg_end  output  IDX_W  last bin of current segment
seg_last  output  1  marks segment K (seg_end = I-1)
total_cost  output  BIT_WIDTH  F(K,I-1); valid while seg_valid

Behaviour:
- Reset (async, rst_n_in=0): state IDLE; busy, e_ready, seg_valid, seg_last = 0; seg_end, total_cost = 0. F/B stores are not cleared.
- Reset mid-frame aborts the frame; the next start runs cleanly.
- K latch: cfg_segs is clamped to [1,MAX_SEG] on latch. start is ignored while busy.
- E stream order: columns i = 0..I-1, and j ascending 0..i within each column. Total I(I+1)/2 words. A transfer occurs when e_valid && e_ready.
- Recurrence:
  - F(1,i) = E(0,i).
  - F(k,i) = min over j' in 1..i of F(k-1,j'-1) + E(j',i), for k = 2..K.
  - B(k,i) = argmin(j'-1).
  - Additions saturate at INF = all-ones; INF + x = INF.
  - Comparison is strict <, so ties keep the lowest j'.
  - F(k,i) is INF when no candidate exists (i < k-1).
- Pipeline: S1 registers the E word and reads the F stores at j'-1 for all levels in parallel. S2 performs K-1 parallel saturating adds and compares into per-level running minima.
- States:
  - IDLE: start → ACCUM.
  - ACCUM: e_ready=1. On the last word of column i → COMMIT.
  - COMMIT: e_ready=0 for exactly 1 cycle. Writes F(k,i) and B(k,i) for k = 1..K and resets the minima. If i = I-1 → TRACE, else → ACCUM with i+1.
  - TRACE: walks b = I-1, level K..2, b ← B(k,b). Stores K ends in a register file. Takes K-1 cycles plus read latency, then → EMIT.
  - EMIT: presents ends in ascending order, segment 1 first. seg_end, seg_last and total_cost stay stable while seg_ready=0. The handshake on seg_last → IDLE and busy drops the next cycle.
- Levels above K are neither written nor used.

Optional Feature:
SEGMENT_DP_MIN_WIDTH2_EN
- Defined: every segment spans at least 2 bins.
  - F(1,0) = INF.
  - The candidate j' = i is skipped for k ≥ 2.
  - If K > I/2 the result is INF, and ends are still emitted from whatever B holds.
- Undefined: single-bin segments are allowed, as described above.

Decomposition:
- Package segment_dp_pkg: state enum (IDLE, ACCUM, COMMIT, TRACE, EMIT), INF constant function, sat_add function.
- Sub-module seg_min_lane: one level's saturating add, compare, running min and argmin. Instantiated MAX_SEG-1 times.

Test Plan (I=4, MAX_SEG=2 unless noted):
- All E=0, K=2 → ends 0 then 3 (seg_last on 3), total_cost 0. Confirms the tie-lowest rule.
- E(j,i)=10 when j≤1<2≤i, else 0; K=2 → ends 1, 3; total_cost 0.
- All E=0xFFFFFFFF, K=2 → total_cost 0xFFFFFFFF with no wrap. Ends emitted, busy clears.
- K=1, E(0,3)=7 → single word seg_end 3, seg_last 1, total_cost 7. cfg_segs=0 behaves as K=1.
- seg_ready held low 5 cycles in EMIT → outputs stable. e_valid toggled randomly → result is unchanged and exactly one e_ready=0 bubble occurs after each column.
- rst_n_in pulsed mid-ACCUM → all outputs 0 asynchronously. A restart with the all-E=0 case reproduces ends 0, 3.

Source files
------------

// File: rtl/segment_dp_pkg.sv
// Shared types and saturating-arithmetic helpers for the segment_dp engine.
// INF is the all-ones word of the active cost width; helpers work on a 64-bit
// carrier so any BIT_WIDTH up to 64 can reuse them.
package segment_dp_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACCUM  = 3'd1,
    COMMIT = 3'd2,
    TRACE  = 3'd3,
    EMIT   = 3'd4
  } sd_state_e;

  localparam int SDP_MAX_W = 64;

  // All-ones value of a w-bit cost word, right-aligned in the carrier.
  function automatic logic [SDP_MAX_W-1:0] inf_val(input int w);
    return {SDP_MAX_W{1'b1}} >> (SDP_MAX_W - w);
  endfunction

  // a + b clipped at INF of width w; INF + x therefore stays INF.
  function automatic logic [SDP_MAX_W-1:0] sat_add(input logic [SDP_MAX_W-1:0] a,
                                                   input logic [SDP_MAX_W-1:0] b,
                                                   input int w);
    logic [SDP_MAX_W:0] s;
    logic [SDP_MAX_W:0] lim;
    lim = {1'b0, inf_val(w)};
    s   = {1'b0, a} + {1'b0, b};
    if (s >= lim) begin
      return inf_val(w);
    end else begin
      return s[SDP_MAX_W-1:0];
    end
  endfunction

endpackage

// File: rtl/segment_dp_min_lane.sv
// seg_min_lane: one DP level's saturating add, strict-less compare and
// running minimum / argmin. o_*_nxt expose the value the lane would hold
// after the current candidate so a column can be committed without waiting
// for the last candidate to land in the registers.
module seg_min_lane
  import segment_dp_pkg::*;
#(
  parameter int BIT_WIDTH = 32,
  parameter int IDX_W     = 8
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 i_clr,
  input  logic                 i_valid,
  input  logic [BIT_WIDTH-1:0] i_f,
  input  logic [BIT_WIDTH-1:0] i_e,
  input  logic [IDX_W-1:0]     i_arg,
  output logic [BIT_WIDTH-1:0] o_min_nxt,
  output logic [IDX_W-1:0]     o_arg_nxt
);

  localparam logic [BIT_WIDTH-1:0] INF_W = BIT_WIDTH'(inf_val(BIT_WIDTH));

  logic [BIT_WIDTH-1:0] r_min;
  logic [IDX_W-1:0]     r_arg;
  logic [BIT_WIDTH-1:0] w_cand;

  // Candidate cost and strict-less selection; ties keep the earlier (lower) split.
  always_comb begin
    w_cand = BIT_WIDTH'(sat_add(SDP_MAX_W'(i_f), SDP_MAX_W'(i_e), BIT_WIDTH));
    if (i_valid && (w_cand < r_min)) begin
      o_min_nxt = w_cand;
      o_arg_nxt = i_arg;
    end else begin
      o_min_nxt = r_min;
      o_arg_nxt = r_arg;
    end
  end

  // Running minimum; cleared to INF at each column commit and while idle.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_min <= INF_W;
      r_arg <= IDX_W'(0);
    end else if (i_clr) begin
      r_min <= INF_W;
      r_arg <= IDX_W'(0);
    end else begin
      r_min <= o_min_nxt;
      r_arg <= o_arg_nxt;
    end
  end

endmodule

// File: rtl/segment_dp.sv
// segment_dp: streamed DP segmentation of I bins into K <= MAX_SEG segments.
// Optional build macro SEGMENT_DP_MIN_WIDTH2_EN forces every segment to span
// at least two bins (F(1,0)=INF and the single-bin candidate j'=i skipped).
module segment_dp
  import segment_dp_pkg::*;
#(
  parameter int  BIT_WIDTH = 32,
  parameter int  I         = 160,
  parameter int  MAX_SEG   = 5,
  localparam int IDX_W     = $clog2(I),
  localparam int K_W       = $clog2(MAX_SEG + 1)
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 start,
  input  logic [K_W-1:0]       cfg_segs,
  output logic                 busy,
  input  logic                 e_valid,
  output logic                 e_ready,
  input  logic [BIT_WIDTH-1:0] e_data,
  output logic                 seg_valid,
  input  logic                 seg_ready,
  output logic [IDX_W-1:0]     seg_end,
  output logic                 seg_last,
  output logic [BIT_WIDTH-1:0] total_cost
);

  localparam int                   NL       = MAX_SEG - 1;
  localparam int                   LV_W     = (MAX_SEG > 1) ? $clog2(MAX_SEG) : 1;
  localparam logic [IDX_W-1:0]     LAST_BIN = IDX_W'(I - 1);
  localparam logic [BIT_WIDTH-1:0] INF_W    = BIT_WIDTH'(inf_val(BIT_WIDTH));

  sd_state_e            r_state;
  logic [K_W-1:0]       r_k;
  logic [K_W-1:0]       r_lvl;
  logic [K_W-1:0]       r_emit;
  logic [IDX_W-1:0]     r_col;
  logic [IDX_W-1:0]     r_row;
  logic [IDX_W-1:0]     r_b;
  logic [BIT_WIDTH-1:0] r_e0;
  logic [BIT_WIDTH-1:0] r_total;
  logic [BIT_WIDTH-1:0] r_f_mem [MAX_SEG][I];
  logic [IDX_W-1:0]     r_b_mem [NL][I];
  logic [IDX_W-1:0]     r_ends  [MAX_SEG];
  logic                 r_s1_valid;
  logic [BIT_WIDTH-1:0] r_s1_e;
  logic [IDX_W-1:0]     r_s1_arg;
  logic [BIT_WIDTH-1:0] r_s1_f  [NL];

  logic                 w_xfer;
  logic                 w_commit;
  logic                 w_lane_clr;
  logic [K_W-1:0]       w_k_clamp;
  logic [IDX_W-1:0]     w_rd_addr;
  logic [BIT_WIDTH-1:0] w_f1;
  logic [BIT_WIDTH-1:0] w_f_col [MAX_SEG];
  logic [IDX_W-1:0]     w_b_col [MAX_SEG];
  logic [IDX_W-1:0]     w_arg   [NL];
  logic [IDX_W-1:0]     w_bk;

  assign w_xfer     = e_valid && e_ready;
  assign w_commit   = (r_state == COMMIT);
  assign w_lane_clr = w_commit || (r_state == IDLE);
  assign w_bk       = w_b_col[LV_W'(r_lvl - K_W'(1))];

  // Requested K clamped into 1..MAX_SEG.
  always_comb begin
    if (cfg_segs == K_W'(0)) begin
      w_k_clamp = K_W'(1);
    end else if (cfg_segs > K_W'(MAX_SEG)) begin
      w_k_clamp = K_W'(MAX_SEG);
    end else begin
      w_k_clamp = cfg_segs;
    end
  end

  // F-store read address j'-1 for the incoming word (row 0 has no candidate).
  always_comb begin
    if (r_row != IDX_W'(0)) begin
      w_rd_addr = r_row - IDX_W'(1);
    end else begin
      w_rd_addr = IDX_W'(0);
    end
  end

  // Level-1 cost for the column being committed.
  always_comb begin
`ifdef SEGMENT_DP_MIN_WIDTH2_EN
    if (r_col == IDX_W'(0)) begin
      w_f1 = INF_W;
    end else begin
      w_f1 = r_e0;
    end
`else
    w_f1 = r_e0;
`endif
  end

  assign w_f_col[0] = w_f1;
  assign w_b_col[0] = IDX_W'(0);

  genvar gl;
  generate
    for (gl = 0; gl < NL; gl++) begin : g_lane
      seg_min_lane #(
        .BIT_WIDTH (BIT_WIDTH),
        .IDX_W     (IDX_W)
      ) u_lane (
        .clk_in    (clk_in),
        .rst_n_in  (rst_n_in),
        .i_clr     (w_lane_clr),
        .i_valid   (r_s1_valid),
        .i_f       (r_s1_f[gl]),
        .i_e       (r_s1_e),
        .i_arg     (r_s1_arg),
        .o_min_nxt (w_f_col[gl+1]),
        .o_arg_nxt (w_arg[gl])
      );
      assign w_b_col[gl+1] = r_b_mem[gl][r_b];
    end
  endgenerate

  // Stage 1: register the accepted E word and the F(k-1, j'-1) reads of every level.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_s1_valid <= 1'b0;
      r_s1_e     <= BIT_WIDTH'(0);
      r_s1_arg   <= IDX_W'(0);
      r_e0       <= BIT_WIDTH'(0);
      for (int l = 0; l < NL; l++) r_s1_f[l] <= BIT_WIDTH'(0);
    end else begin
`ifdef SEGMENT_DP_MIN_WIDTH2_EN
      r_s1_valid <= w_xfer && (r_row != IDX_W'(0)) && (r_row != r_col);
`else
      r_s1_valid <= w_xfer && (r_row != IDX_W'(0));
`endif
      r_s1_e   <= e_data;
      r_s1_arg <= w_rd_addr;
      for (int l = 0; l < NL; l++) r_s1_f[l] <= r_f_mem[l][w_rd_addr];
      if (w_xfer && (r_row == IDX_W'(0))) begin
        r_e0 <= e_data;
      end
    end
  end

  // Column commit: write F and B for active levels only; stores are never cleared.
  always_ff @(posedge clk_in) begin
    if (w_commit) begin
      for (int l = 0; l < MAX_SEG; l++) begin
        if (l < int'(r_k)) r_f_mem[l][r_col] <= w_f_col[l];
      end
      for (int l = 0; l < NL; l++) begin
        if (l + 2 <= int'(r_k)) r_b_mem[l][r_col] <= w_arg[l];
      end
    end
  end

  // Control FSM: stream columns, commit, trace back boundaries, emit them.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state    <= IDLE;
      busy       <= 1'b0;
      e_ready    <= 1'b0;
      seg_valid  <= 1'b0;
      seg_last   <= 1'b0;
      seg_end    <= IDX_W'(0);
      total_cost <= BIT_WIDTH'(0);
      r_k        <= K_W'(1);
      r_lvl      <= K_W'(0);
      r_emit     <= K_W'(0);
      r_col      <= IDX_W'(0);
      r_row      <= IDX_W'(0);
      r_b        <= IDX_W'(0);
      r_total    <= BIT_WIDTH'(0);
      for (int s = 0; s < MAX_SEG; s++) r_ends[s] <= IDX_W'(0);
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_k     <= w_k_clamp;
            busy    <= 1'b1;
            e_ready <= 1'b1;
            r_col   <= IDX_W'(0);
            r_row   <= IDX_W'(0);
            r_state <= ACCUM;
          end
        end
        ACCUM: begin
          if (w_xfer) begin
            if (r_row == r_col) begin
              e_ready <= 1'b0;
              r_state <= COMMIT;
            end else begin
              r_row <= r_row + IDX_W'(1);
            end
          end
        end
        COMMIT: begin
          r_row <= IDX_W'(0);
          if (r_col == LAST_BIN) begin
            r_total                        <= w_f_col[LV_W'(r_k - K_W'(1))];
            r_ends[LV_W'(r_k - K_W'(1))]   <= LAST_BIN;
            r_b                            <= LAST_BIN;
            r_lvl                          <= r_k;
            r_state                        <= TRACE;
          end else begin
            r_col   <= r_col + IDX_W'(1);
            e_ready <= 1'b1;
            r_state <= ACCUM;
          end
        end
        TRACE: begin
          if (r_lvl > K_W'(1)) begin
            r_ends[LV_W'(r_lvl - K_W'(2))] <= w_bk;
            r_b                            <= w_bk;
            r_lvl                          <= r_lvl - K_W'(1);
          end else begin
            seg_valid  <= 1'b1;
            seg_end    <= r_ends[0];
            seg_last   <= (r_k == K_W'(1));
            total_cost <= r_total;
            r_emit     <= K_W'(1);
            r_state    <= EMIT;
          end
        end
        EMIT: begin
          if (seg_ready) begin
            if (seg_last) begin
              seg_valid <= 1'b0;
              seg_last  <= 1'b0;
              busy      <= 1'b0;
              r_state   <= IDLE;
            end else begin
              seg_end  <= r_ends[LV_W'(r_emit)];
              seg_last <= ((r_emit + K_W'(1)) == r_k);
              r_emit   <= r_emit + K_W'(1);
            end
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
